// File: rtl/fht_stream_ctrl_pkg.sv
// rtl/fht_stream_ctrl_pkg.sv - shared widths, FSM encoding and helpers for the FHT stream controller
package fht_stream_ctrl_pkg;

   localparam int D_BIT_DEF     = 16;
   localparam int A_BIT_DEF     = 8;
   localparam int BANK_SIZE_DEF = 256;

   typedef enum logic [2:0] {
      ST_LOAD    = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT_LO = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_UNLOAD  = 3'd4
   } state_e;

   // Sample n lands in bank (n mod 4); returns the one-hot write enable.
   function automatic logic [3:0] bank_onehot(input logic [1:0] idx);
      bank_onehot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/fht_out_serializer.sv
// rtl/fht_out_serializer.sv - 4-word capture buffer emitting bank0..bank3 on a valid/ready stream
module fht_out_serializer
   import fht_stream_ctrl_pkg::*;
#(
   parameter int D_BIT = D_BIT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [D_BIT-1:0] word_0,
   input  logic [D_BIT-1:0] word_1,
   input  logic [D_BIT-1:0] word_2,
   input  logic [D_BIT-1:0] word_3,
   input  logic             last_grp,
   input  logic             m_ready,
   output logic             can_load,
   output logic             done,
   output logic [D_BIT-1:0] m_data,
   output logic             m_valid,
   output logic             m_last
);

   logic [3:0][D_BIT-1:0] buf_q, buf_d;
   logic [1:0]            idx_q, idx_d;
   logic                  valid_q, valid_d;
   logic                  last_grp_q, last_grp_d;
   logic                  hs;
   logic                  word3_hs;

   // A new group may be captured when empty or on the edge that retires word 3,
   // which is what keeps the stream free of bubbles between groups.
   assign hs       = valid_q & m_ready;
   assign word3_hs = hs & (idx_q == 2'd3);
   assign can_load = ~valid_q | word3_hs;
   assign done     = word3_hs & last_grp_q;
   assign m_valid  = valid_q;
   assign m_data   = buf_q[idx_q];
   assign m_last   = valid_q & last_grp_q & (idx_q == 2'd3);

   // Next-state: capture overrides advance; the buffer only moves on a handshake.
   always_comb begin
      buf_d      = buf_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      last_grp_d = last_grp_q;
      if (load) begin
         buf_d      = {word_3, word_2, word_1, word_0};
         idx_d      = 2'd0;
         valid_d    = 1'b1;
         last_grp_d = last_grp;
      end else if (hs) begin
         if (idx_q == 2'd3) begin
            valid_d = 1'b0;
         end else begin
            idx_d = idx_q + 2'd1;
         end
      end
   end

   // Buffer, word index and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q      <= '0;
         idx_q      <= 2'd0;
         valid_q    <= 1'b0;
         last_grp_q <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         last_grp_q <= last_grp_d;
      end
   end

endmodule

// File: rtl/fht_stream_ctrl.sv
// rtl/fht_stream_ctrl.sv - host-side load/start/unload controller for the FHT core
module fht_stream_ctrl
   import fht_stream_ctrl_pkg::*;
#(
   parameter int D_BIT     = D_BIT_DEF,
   parameter int A_BIT     = A_BIT_DEF,
   parameter int BANK_SIZE = BANK_SIZE_DEF
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic [D_BIT-1:0] iS_DATA,
   input  logic             iS_VALID,
   output logic             oS_READY,
   output logic [3:0]       oFHT_WE,
   output logic [D_BIT-1:0] oFHT_DATA,
   output logic [A_BIT-1:0] oFHT_ADDR_WR,
   output logic             oFHT_START,
   input  logic             iFHT_RDY,
   output logic [A_BIT-1:0] oFHT_ADDR_RD_0,
   output logic [A_BIT-1:0] oFHT_ADDR_RD_1,
   output logic [A_BIT-1:0] oFHT_ADDR_RD_2,
   output logic [A_BIT-1:0] oFHT_ADDR_RD_3,
   input  logic [D_BIT-1:0] iFHT_DATA_0,
   input  logic [D_BIT-1:0] iFHT_DATA_1,
   input  logic [D_BIT-1:0] iFHT_DATA_2,
   input  logic [D_BIT-1:0] iFHT_DATA_3,
   output logic [D_BIT-1:0] oM_DATA,
   output logic             oM_VALID,
   input  logic             iM_READY,
   output logic             oM_LAST,
   output logic             oBUSY
);

   localparam int               CW          = A_BIT + 2;
   localparam int               N           = 4 * BANK_SIZE;
   localparam logic [CW-1:0]    LAST_SAMPLE = CW'(N - 1);
   localparam logic [A_BIT-1:0] LAST_ADDR   = A_BIT'(BANK_SIZE - 1);
   localparam logic [A_BIT:0]   GROUPS      = (A_BIT + 1)'(BANK_SIZE);
   localparam logic [A_BIT:0]   LAST_GROUP  = (A_BIT + 1)'(BANK_SIZE - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    n_q, n_d;
   logic [3:0]       we_q, we_d;
   logic [A_BIT-1:0] wr_addr_q, wr_addr_d;
   logic [D_BIT-1:0] wr_data_q, wr_data_d;
   logic             start_q, start_d;
   logic [A_BIT-1:0] rd_addr_q, rd_addr_d;
   logic             rd_vld_q, rd_vld_d;   // bank data reflects rd_addr_q
   logic [A_BIT:0]   grp_q, grp_d;         // groups captured so far this unload
   logic             ser_load;
   logic             ser_can_load;
   logic             ser_done;

   assign oS_READY       = (state_q == ST_LOAD);
   assign oBUSY          = (state_q != ST_LOAD);
   assign oFHT_WE        = we_q;
   assign oFHT_DATA      = wr_data_q;
   assign oFHT_ADDR_WR   = wr_addr_q;
   assign oFHT_START     = start_q;
   assign oFHT_ADDR_RD_0 = rd_addr_q;
   assign oFHT_ADDR_RD_1 = rd_addr_q;
   assign oFHT_ADDR_RD_2 = rd_addr_q;
   assign oFHT_ADDR_RD_3 = rd_addr_q;

   // Frame FSM plus write scatter and read-address prefetch.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      we_d      = 4'b0000;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      start_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_vld_d  = rd_vld_q;
      grp_d     = grp_q;
      ser_load  = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (iS_VALID) begin
               we_d      = bank_onehot(n_q[1:0]);
               wr_addr_d = n_q[CW-1:2];
               wr_data_d = iS_DATA;
               if (n_q == LAST_SAMPLE) begin
                  n_d     = '0;
                  state_d = ST_START;
               end else begin
                  n_d = n_q + 1'b1;
               end
            end
         end
         ST_START: begin
            start_d = 1'b1;
            state_d = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            // Drop any ready level left over from the previous frame first.
            if (!iFHT_RDY) begin
               state_d = ST_WAIT_HI;
            end
         end
         ST_WAIT_HI: begin
            if (iFHT_RDY) begin
               state_d   = ST_UNLOAD;
               rd_addr_d = '0;
               rd_vld_d  = 1'b0;
               grp_d     = '0;
            end
         end
         ST_UNLOAD: begin
            rd_vld_d = 1'b1;
            if (rd_vld_q && ser_can_load && (grp_q != GROUPS)) begin
               ser_load = 1'b1;
               grp_d    = grp_q + 1'b1;
               // Prefetch the next group; the final address is held, never wrapped.
               if (rd_addr_q != LAST_ADDR) begin
                  rd_addr_d = rd_addr_q + 1'b1;
                  rd_vld_d  = 1'b0;
               end
            end
            if (ser_done) begin
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Controller registers.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q   <= ST_LOAD;
         n_q       <= '0;
         we_q      <= 4'b0000;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         start_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_vld_q  <= 1'b0;
         grp_q     <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         we_q      <= we_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         start_q   <= start_d;
         rd_addr_q <= rd_addr_d;
         rd_vld_q  <= rd_vld_d;
         grp_q     <= grp_d;
      end
   end

   fht_out_serializer #(
      .D_BIT (D_BIT)
   ) u_ser (
      .clk      (iCLK),
      .rst_n    (iRESET),
      .load     (ser_load),
      .word_0   (iFHT_DATA_0),
      .word_1   (iFHT_DATA_1),
      .word_2   (iFHT_DATA_2),
      .word_3   (iFHT_DATA_3),
      .last_grp (grp_q == LAST_GROUP),
      .m_ready  (iM_READY),
      .can_load (ser_can_load),
      .done     (ser_done),
      .m_data   (oM_DATA),
      .m_valid  (oM_VALID),
      .m_last   (oM_LAST)
   );

endmodule

// File: tb/tb_fht_stream_ctrl.sv
// tb/tb_fht_stream_ctrl.sv - directed, table-driven bench for fht_stream_ctrl
module tb_fht_stream_ctrl;

   localparam int N = 1024;

   logic        iCLK = 1'b0;
   logic        iRESET;
   logic [15:0] iS_DATA;
   logic        iS_VALID;
   logic        oS_READY;
   logic [3:0]  oFHT_WE;
   logic [15:0] oFHT_DATA;
   logic [7:0]  oFHT_ADDR_WR;
   logic        oFHT_START;
   logic        iFHT_RDY;
   logic [7:0]  oFHT_ADDR_RD_0, oFHT_ADDR_RD_1, oFHT_ADDR_RD_2, oFHT_ADDR_RD_3;
   logic [15:0] iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3;
   logic [15:0] oM_DATA;
   logic        oM_VALID;
   logic        iM_READY;
   logic        oM_LAST;
   logic        oBUSY;

   int checks = 0;
   int errors = 0;

   typedef struct { int n; int we; int addr; int data; } wr_vec_t;
   typedef struct { int beat; int data; int last; } rd_vec_t;
   wr_vec_t wr_tab [7];
   rd_vec_t rd_tab [8];

   fht_stream_ctrl dut (
      .iCLK(iCLK), .iRESET(iRESET),
      .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
      .oFHT_WE(oFHT_WE), .oFHT_DATA(oFHT_DATA), .oFHT_ADDR_WR(oFHT_ADDR_WR),
      .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY),
      .oFHT_ADDR_RD_0(oFHT_ADDR_RD_0), .oFHT_ADDR_RD_1(oFHT_ADDR_RD_1),
      .oFHT_ADDR_RD_2(oFHT_ADDR_RD_2), .oFHT_ADDR_RD_3(oFHT_ADDR_RD_3),
      .iFHT_DATA_0(iFHT_DATA_0), .iFHT_DATA_1(iFHT_DATA_1),
      .iFHT_DATA_2(iFHT_DATA_2), .iFHT_DATA_3(iFHT_DATA_3),
      .oM_DATA(oM_DATA), .oM_VALID(oM_VALID), .iM_READY(iM_READY),
      .oM_LAST(oM_LAST), .oBUSY(oBUSY)
   );

   always #5 iCLK = ~iCLK;

   // Bank model: registered read, bank k address a returns 1000*k + a.
   always @(posedge iCLK) begin
      iFHT_DATA_0 <= 16'(int'(oFHT_ADDR_RD_0));
      iFHT_DATA_1 <= 16'(1000 + int'(oFHT_ADDR_RD_1));
      iFHT_DATA_2 <= 16'(2000 + int'(oFHT_ADDR_RD_2));
      iFHT_DATA_3 <= 16'(3000 + int'(oFHT_ADDR_RD_3));
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_write(input int pend);
      if (pend < 0) begin
         chk("we_idle", oFHT_WE, 0);
      end else begin
         chk("we", oFHT_WE, 1 << (pend % 4));
         chk("wr_addr", oFHT_ADDR_WR, pend / 4);
         chk("wr_data", oFHT_DATA, pend);
         for (int i = 0; i < 7; i++) begin
            if (wr_tab[i].n == pend) begin
               chk("tab_we", oFHT_WE, wr_tab[i].we);
               chk("tab_addr", oFHT_ADDR_WR, wr_tab[i].addr);
               chk("tab_data", oFHT_DATA, wr_tab[i].data);
            end
         end
      end
   endtask

   task automatic check_reset_values();
      chk("rst_s_ready", oS_READY, 1);
      chk("rst_we", oFHT_WE, 0);
      chk("rst_wr_addr", oFHT_ADDR_WR, 0);
      chk("rst_wr_data", oFHT_DATA, 0);
      chk("rst_start", oFHT_START, 0);
      chk("rst_rd_addr", oFHT_ADDR_RD_0, 0);
      chk("rst_m_valid", oM_VALID, 0);
      chk("rst_m_last", oM_LAST, 0);
      chk("rst_busy", oBUSY, 0);
   endtask

   task automatic do_reset();
      @(negedge iCLK);
      iS_VALID = 1'b0;
      iM_READY = 1'b0;
      #2 iRESET = 1'b0;
      #1 check_reset_values();
      @(negedge iCLK);
      iRESET = 1'b1;
      repeat (3) begin
         @(negedge iCLK);
         chk("post_rst_start", oFHT_START, 0);
         chk("post_rst_busy", oBUSY, 0);
      end
   endtask

   task automatic load_frame(input int idle_pct, input int stop_at);
      int n = 0;
      int pend = -1;
      int cyc = 0;
      iFHT_RDY = 1'b1;
      while (n < N) begin
         @(negedge iCLK);
         cyc++;
         check_write(pend);
         if (n == stop_at) begin
            iS_VALID = 1'b0;
            return;
         end
         if (cyc > 20000) begin
            chk("load_timeout", 0, 1);
            iS_VALID = 1'b0;
            return;
         end
         chk("s_ready_load", oS_READY, 1);
         pend = -1;
         if (int'($urandom_range(99)) < idle_pct) begin
            iS_VALID = 1'b0;
         end else begin
            iS_VALID = 1'b1;
            iS_DATA  = 16'(n);
            pend     = n;
            n++;
         end
      end
      @(negedge iCLK);
      iS_VALID = 1'b0;
      check_write(pend);
      chk("s_ready_after_last", oS_READY, 0);
      chk("start_early", oFHT_START, 0);
      @(negedge iCLK);
      chk("start_pulse", oFHT_START, 1);
      chk("we_at_start", oFHT_WE, 0);
      @(negedge iCLK);
      chk("start_single", oFHT_START, 0);
   endtask

   task automatic run_fht();
      for (int i = 0; i < 53; i++) begin
         if (i == 3) iFHT_RDY = 1'b0;
         @(negedge iCLK);
         chk("wait_busy", oBUSY, 1);
         chk("wait_we", oFHT_WE, 0);
         chk("wait_valid", oM_VALID, 0);
         chk("wait_start", oFHT_START, 0);
         iS_VALID = 1'b1;
      end
      iS_VALID = 1'b0;
      iFHT_RDY = 1'b1;
      @(negedge iCLK);
      chk("unload_lat0", oM_VALID, 0);
      @(negedge iCLK);
      chk("unload_lat1", oM_VALID, 0);
      @(negedge iCLK);
      chk("unload_first_valid", oM_VALID, 1);
   endtask

   task automatic unload(input int rdy_pct, input int stop_at, input int stall_at);
      int b = 0;
      int cyc = 0;
      int bubbles = 0;
      int a0;
      int d0;
      bit stalled = 0;
      while (b < N) begin
         if (b == stop_at) return;
         if (cyc > 20000) begin
            chk("unload_timeout", 0, 1);
            return;
         end
         chk("busy_unload", oBUSY, 1);
         if (oM_VALID) begin
            chk("m_data", oM_DATA, 1000 * (b % 4) + b / 4);
            chk("m_last", oM_LAST, int'(b == N - 1));
            for (int i = 0; i < 8; i++) begin
               if (rd_tab[i].beat == b) begin
                  chk("tab_m_data", oM_DATA, rd_tab[i].data);
                  chk("tab_m_last", oM_LAST, rd_tab[i].last);
               end
            end
         end else begin
            bubbles++;
         end
         if (b == stall_at && !stalled) begin
            stalled = 1;
            iM_READY = 1'b0;
            a0 = int'(oFHT_ADDR_RD_0);
            d0 = int'(oM_DATA);
            repeat (30) begin
               @(negedge iCLK);
               chk("stall_valid", oM_VALID, 1);
               chk("stall_data", oM_DATA, d0);
               chk("stall_addr", oFHT_ADDR_RD_0, a0);
            end
         end
         iM_READY = (int'($urandom_range(99)) < rdy_pct);
         iFHT_RDY = 1'($urandom_range(1));
         if (oM_VALID && iM_READY) b++;
         @(negedge iCLK);
         cyc++;
      end
      iM_READY = 1'b0;
      chk("bubbles", bubbles, 0);
      if (rdy_pct >= 100) chk("unload_cycles", cyc, N);
      chk("valid_after_last", oM_VALID, 0);
      chk("last_after_last", oM_LAST, 0);
      chk("s_ready_after_unload", oS_READY, 1);
      chk("busy_after_unload", oBUSY, 0);
      chk("rd_addr_hold0", oFHT_ADDR_RD_0, 255);
      chk("rd_addr_hold3", oFHT_ADDR_RD_3, 255);
   endtask

   initial begin
      wr_tab[0] = '{0,    1, 0,   0};
      wr_tab[1] = '{1,    2, 0,   1};
      wr_tab[2] = '{2,    4, 0,   2};
      wr_tab[3] = '{3,    8, 0,   3};
      wr_tab[4] = '{4,    1, 1,   4};
      wr_tab[5] = '{517,  2, 129, 517};
      wr_tab[6] = '{1023, 8, 255, 1023};
      rd_tab[0] = '{0,    0,    0};
      rd_tab[1] = '{1,    1000, 0};
      rd_tab[2] = '{2,    2000, 0};
      rd_tab[3] = '{3,    3000, 0};
      rd_tab[4] = '{4,    1,    0};
      rd_tab[5] = '{5,    1001, 0};
      rd_tab[6] = '{514,  2128, 0};
      rd_tab[7] = '{1023, 3255, 1};

      iRESET   = 1'b0;
      iS_DATA  = '0;
      iS_VALID = 1'b0;
      iFHT_RDY = 1'b1;
      iM_READY = 1'b0;
      #3 check_reset_values();
      @(negedge iCLK);
      iRESET = 1'b1;

      load_frame(0, -1);
      run_fht();
      unload(100, -1, -1);

      load_frame(30, -1);
      run_fht();
      unload(50, -1, 100);

      load_frame(0, 500);
      do_reset();
      load_frame(10, -1);
      run_fht();
      unload(100, 300, -1);
      do_reset();
      load_frame(0, -1);
      run_fht();
      unload(100, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
